// File: rtl/gpio_pkg.sv
// Shared field positions, default address map and FSM state type
// for the GPIO stream reader.
package gpio_pkg;

    localparam int WCLK_BIT = 31;
    localparam int ADDR_LSB = 16;
    localparam int ADDR_W   = 8;

    localparam logic [7:0] DEF_CH_BASE    = 8'h20;
    localparam logic [7:0] DEF_STAT_BASE  = 8'h40;
    localparam logic [7:0] DEF_SYNC_ADDR  = 8'h3F;
    localparam logic [7:0] DEF_FLAGS_ADDR = 8'h3E;
    localparam logic [7:0] ERR_OFS        = 8'h80;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    function automatic int words_of(input int w);
        return (w + 31) / 32;
    endfunction

endpackage

// File: rtl/gpio_stream_reader_ch.sv
// One readback channel: word counter, word-slice mux and the
// one-cycle ch_ready pulse that retires a beat.
module gpio_stream_reader_ch
    import gpio_pkg::*;
#(
    parameter int CH_WIDTH = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH_WIDTH-1:0] data,
    input  logic                ch_valid,
    input  logic                rd_en,
    input  logic                sync,
    output logic [31:0]         word,
    output logic                ch_ready
);

    localparam int WORDS = words_of(CH_WIDTH);
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    logic [WORDS*32-1:0] padded;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ready_q, ready_d;

    always_comb begin
        padded = '0;
        padded[CH_WIDTH-1:0] = data;
    end

    always_comb begin
        word = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (cnt_q == CW'(i)) begin
                word = padded[i*32 +: 32];
            end
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        ready_d = 1'b0;
        if (sync) begin
            cnt_d = '0;
        end else if (rd_en && ch_valid) begin
            if (cnt_q == LAST) begin
                cnt_d   = '0;
                ready_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // never offer ready without a matching valid
    assign ch_ready = ready_q & ch_valid;

endmodule

// File: rtl/gpio_stream_reader.sv
// GPIO strobe-driven reader of AXI-stream channels and status words.
// Optional failed-read counter: GPIO_STREAM_READER_ERRCNT_EN.
module gpio_stream_reader
    import gpio_pkg::*;
#(
    parameter int         NUM_CH     = 4,
    parameter int         CH_WIDTH   = 128,
    parameter int         NUM_STAT   = 4,
    parameter logic [7:0] CH_BASE    = DEF_CH_BASE,
    parameter logic [7:0] STAT_BASE  = DEF_STAT_BASE,
    parameter logic [7:0] SYNC_ADDR  = DEF_SYNC_ADDR,
    parameter logic [7:0] FLAGS_ADDR = DEF_FLAGS_ADDR
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [31:0]                            gpio_in,
    output logic [31:0]                            gpio_out,
    output logic                                   valid,
    input  logic [NUM_CH*CH_WIDTH-1:0]             ch_data,
    input  logic [NUM_CH-1:0]                      ch_valid,
    output logic [NUM_CH-1:0]                      ch_ready,
    input  logic [(NUM_STAT > 0 ? NUM_STAT : 1)*32-1:0] stat_in
);

    localparam logic [7:0] ERR_ADDR = FLAGS_ADDR + ERR_OFS;

    logic        w_clk;
    logic [7:0]  addr;
    logic        wclk_q, wclk_d;
    state_e      state_q, state_d;
    logic        rd_ok_q, rd_ok_d;
    logic [31:0] data_q, data_d;
    logic        rise, rd_go, sync, is_ch;
    logic [8:0]  ch_ofs;
    logic [NUM_CH-1:0] ch_sel, rd_en;
    logic [31:0] ch_word [NUM_CH];
    logic [31:0] sel_word, err_word;
    logic        sel_valid;
    logic        unused_ok;

    assign w_clk     = gpio_in[WCLK_BIT];
    assign addr      = gpio_in[ADDR_LSB +: ADDR_W];
    assign unused_ok = ^{gpio_in[30:24], gpio_in[15:0]};

    assign wclk_d = w_clk;
    assign rise   = w_clk & ~wclk_q;
    assign rd_go  = (state_q == ST_IDLE) && rise;
    assign sync   = rd_go && (addr == SYNC_ADDR);

    assign ch_ofs = {1'b0, addr} - {1'b0, CH_BASE};
    assign is_ch  = (addr >= CH_BASE)
                 && ({1'b0, addr} < ({1'b0, CH_BASE} + 9'(NUM_CH)));
    assign rd_en  = {NUM_CH{rd_go}} & ch_sel;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign ch_sel[k] = is_ch && (ch_ofs == 9'(k));

        gpio_stream_reader_ch #(
            .CH_WIDTH (CH_WIDTH)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .data     (ch_data[k*CH_WIDTH +: CH_WIDTH]),
            .ch_valid (ch_valid[k]),
            .rd_en    (rd_en[k]),
            .sync     (sync),
            .word     (ch_word[k]),
            .ch_ready (ch_ready[k])
        );
    end

    always_comb begin
        sel_word  = '0;
        sel_valid = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_sel[k]) begin
                sel_word  = ch_word[k];
                sel_valid = ch_valid[k];
            end
        end
    end

    // every accepted edge parks in HOLD until w_clk falls
    always_comb begin
        state_d = state_q;
        rd_ok_d = rd_ok_q;
        data_d  = data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_HOLD;
                    rd_ok_d = is_ch && sel_valid;
                    if (is_ch && sel_valid) begin
                        data_d = sel_word;
                    end
                end
            end
            ST_HOLD: begin
                if (!w_clk) begin
                    state_d = ST_IDLE;
                    rd_ok_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wclk_q  <= 1'b0;
            state_q <= ST_IDLE;
            rd_ok_q <= 1'b0;
            data_q  <= '0;
        end else begin
            wclk_q  <= wclk_d;
            state_q <= state_d;
            rd_ok_q <= rd_ok_d;
            data_q  <= data_d;
        end
    end

`ifdef GPIO_STREAM_READER_ERRCNT_EN
    logic [15:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == ST_HOLD && !w_clk && addr == ERR_ADDR) begin
            err_d = '0;
        end else if (rd_go && is_ch && !sel_valid
                     && err_q != 16'hFFFF) begin
            err_d = err_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_word = {16'h0000, err_q};
`else
    assign err_word = '0;
`endif

    always_comb begin
        gpio_out = '0;
        if (is_ch) begin
            gpio_out = data_q;
        end else if (addr == FLAGS_ADDR) begin
            gpio_out = 32'(ch_valid);
        end else if (addr == ERR_ADDR) begin
            gpio_out = err_word;
        end else begin
            for (int i = 0; i < NUM_STAT; i++) begin
                if ({1'b0, addr} == ({1'b0, STAT_BASE} + 9'(i))) begin
                    gpio_out = stat_in[i*32 +: 32];
                end
            end
        end
    end

    assign valid = is_ch ? rd_ok_q : 1'b1;

endmodule
